// File: rtl/candy_pkg.sv
// Shared key codes, keypad geometry and emulator state encoding for the
// candy vending machine keypad path (scanner, emulator, controller).
package candy_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOUNCE_IN,
    ST_HOLD,
    ST_BOUNCE_OUT,
    ST_GAP
  } emu_state_t;

  function automatic logic key_is_valid(input logic [3:0] key);
    return key <= KEY_HASH;
  endfunction

endpackage

// File: rtl/keypad_contact_map.sv
// Combinational key-code to (row, col) decode in phone layout; pulls the key's
// row low when the contact is closed and its column is driven low. Zero latency.
module keypad_contact_map
  import candy_pkg::*;
(
  input  logic [3:0]          key_i,
  input  logic [NUM_COLS-1:0] col_i,
  input  logic                contact_i,
  output logic                valid_o,
  output logic [NUM_ROWS-1:0] row_o
);

  logic [1:0] kr;
  logic [1:0] kc;
  logic       col_hit;

  always_comb begin
    kr      = 2'd0;
    kc      = 2'd0;
    valid_o = 1'b1;
    case (key_i)
      KEY_1:    begin kr = 2'd0; kc = 2'd0; end
      KEY_2:    begin kr = 2'd0; kc = 2'd1; end
      KEY_3:    begin kr = 2'd0; kc = 2'd2; end
      KEY_4:    begin kr = 2'd1; kc = 2'd0; end
      KEY_5:    begin kr = 2'd1; kc = 2'd1; end
      KEY_6:    begin kr = 2'd1; kc = 2'd2; end
      KEY_7:    begin kr = 2'd2; kc = 2'd0; end
      KEY_8:    begin kr = 2'd2; kc = 2'd1; end
      KEY_9:    begin kr = 2'd2; kc = 2'd2; end
      KEY_STAR: begin kr = 2'd3; kc = 2'd0; end
      KEY_0:    begin kr = 2'd3; kc = 2'd1; end
      KEY_HASH: begin kr = 2'd3; kc = 2'd2; end
      default:  valid_o = 1'b0;
    endcase
  end

  // Only the latched key's column matters; other low columns are ignored.
  always_comb begin
    col_hit = 1'b0;
    case (kc)
      2'd0:    col_hit = !col_i[0];
      2'd1:    col_hit = !col_i[1];
      2'd2:    col_hit = !col_i[2];
      default: col_hit = 1'b0;
    endcase
  end

  always_comb begin
    row_o = '1;
    if (contact_i && valid_o && col_hit) begin
      row_o[kr] = 1'b0;
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// 4x3 keypad responder: one key per valid/ready request, contact closes the cycle
// after acceptance; requests stall (req_ready=0) for the whole press sequence.
module keypad_emulator
  import candy_pkg::*;
#(
  parameter int HOLD_CYCLES   = 200,
  parameter int GAP_CYCLES    = 50,
  parameter int BOUNCE_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [3:0]          req_key,
  output logic                req_ready,
  input  logic [NUM_COLS-1:0] col,
  output logic [NUM_ROWS-1:0] row,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] BOUNCE_LD = CW'(BOUNCE_CYCLES - 1);
  localparam logic          HAS_BOUNCE = (BOUNCE_CYCLES > 0);

  emu_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic          contact_q;
  logic [3:0]    key_q;
  logic          done_q;
  logic          err_q;
  logic          key_ok;

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;

  // The counter holds "cycles remaining minus one" and reloads on every state entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      contact_q <= 1'b0;
      key_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            key_q <= req_key;
            if (key_is_valid(req_key)) begin
              contact_q <= 1'b1;
              if (HAS_BOUNCE) begin
                state_q <= ST_BOUNCE_IN;
                cnt_q   <= BOUNCE_LD;
              end else begin
                state_q <= ST_HOLD;
                cnt_q   <= HOLD_LD;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_BOUNCE_IN: begin
          if (cnt_q == '0) begin
            state_q   <= ST_HOLD;
            cnt_q     <= HOLD_LD;
            contact_q <= 1'b1;
          end else begin
            cnt_q     <= cnt_q - 1'b1;
            contact_q <= !contact_q;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            contact_q <= 1'b0;
            if (HAS_BOUNCE) begin
              state_q <= ST_BOUNCE_OUT;
              cnt_q   <= BOUNCE_LD;
            end else begin
              state_q <= ST_GAP;
              cnt_q   <= GAP_LD;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_BOUNCE_OUT: begin
          if (cnt_q == '0) begin
            state_q   <= ST_GAP;
            cnt_q     <= GAP_LD;
            contact_q <= 1'b0;
          end else begin
            cnt_q     <= cnt_q - 1'b1;
            contact_q <= !contact_q;
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          contact_q <= 1'b0;
        end
      endcase
    end
  end

  keypad_contact_map u_map (
    .key_i     (key_q),
    .col_i     (col),
    .contact_i (contact_q),
    .valid_o   (key_ok),
    .row_o     (row)
  );

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: two instances (no bounce / 3-cycle bounce).
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_vld, a_rdy, a_busy, a_done, a_err;
  logic [3:0] a_key, a_row;
  logic [2:0] a_col;
  logic       b_vld, b_rdy, b_busy, b_done, b_err;
  logic [3:0] b_key, b_row;
  logic [2:0] b_col;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  keypad_emulator #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .BOUNCE_CYCLES(0)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_vld), .req_key(a_key), .req_ready(a_rdy),
    .col(a_col), .row(a_row), .busy(a_busy), .done(a_done), .err(a_err)
  );

  keypad_emulator #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .BOUNCE_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_vld), .req_key(b_key), .req_ready(b_rdy),
    .col(b_col), .row(b_row), .busy(b_busy), .done(b_done), .err(b_err)
  );

  task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int bnc [12] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1};

  initial begin
    reset = 1'b0;
    a_vld = 1'b0; a_key = 4'd0; a_col = 3'b111;
    b_vld = 1'b0; b_key = 4'd0; b_col = 3'b111;

    // Reset state: idle row for every column pattern
    #2;
    for (int c = 0; c < 8; c++) begin
      a_col = 3'(c);
      #1;
      chk4($sformatf("reset_row col%0d", c), a_row, 4'b1111);
    end
    chk1("reset_rdy", a_rdy, 1'b1);
    chk1("reset_busy", a_busy, 1'b0);
    chk1("reset_done", a_done, 1'b0);
    chk1("reset_err", a_err, 1'b0);
    step();
    reset = 1'b1;
    step();

    // Key 5, columns cycling: row1 low only under col 101 during HOLD
    a_key = 4'd5; a_vld = 1'b1;
    step();
    a_vld = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) step();
      chk1($sformatf("k5_busy c%0d", k), a_busy, k <= 6);
      chk1($sformatf("k5_rdy c%0d", k), a_rdy, k >= 7);
      chk1($sformatf("k5_done c%0d", k), a_done, k == 7);
      for (int j = 0; j < 3; j++) begin
        a_col = (j == 0) ? 3'b110 : (j == 1) ? 3'b101 : 3'b011;
        #1;
        chk4($sformatf("k5_row c%0d col%b", k, a_col), a_row,
             (k <= 4 && a_col == 3'b101) ? 4'b1101 : 4'b1111);
      end
    end

    // Key '#' with col2 held low
    a_col = 3'b011; a_key = 4'd11; a_vld = 1'b1;
    #1;
    chk4("hash_row_idle", a_row, 4'b1111);
    step();
    a_vld = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) step();
      chk4($sformatf("hash_row c%0d", k), a_row, (k <= 4) ? 4'b0111 : 4'b1111);
    end

    // Invalid code 13: err pulse only, contact stays open
    a_col = 3'b000; a_key = 4'd13; a_vld = 1'b1;
    step();
    a_vld = 1'b0;
    chk1("inv_err_pulse", a_err, 1'b1);
    chk1("inv_busy", a_busy, 1'b0);
    chk1("inv_rdy", a_rdy, 1'b1);
    chk4("inv_row", a_row, 4'b1111);
    step();
    chk1("inv_err_clear", a_err, 1'b0);
    chk1("inv_busy2", a_busy, 1'b0);
    chk4("inv_row2", a_row, 4'b1111);

    // Bounce instance, key 0 under col1
    b_col = 3'b101; b_key = 4'd0; b_vld = 1'b1;
    step();
    b_vld = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) step();
      chk4($sformatf("bnc_row c%0d", k), b_row, (bnc[k-1] != 0) ? 4'b1111 : 4'b0111);
      chk1($sformatf("bnc_done c%0d", k), b_done, 1'b0);
    end
    step();
    chk1("bnc_done_pulse", b_done, 1'b1);
    chk1("bnc_rdy", b_rdy, 1'b1);

    // Back-to-back keys 1 then 9 with req_valid held
    a_col = 3'b110; a_key = 4'd1; a_vld = 1'b1;
    step();
    a_key = 4'd9;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) step();
      chk4($sformatf("b2b_k1_row c%0d", k), a_row, (k <= 4) ? 4'b1110 : 4'b1111);
      chk1($sformatf("b2b_stall c%0d", k), a_rdy, 1'b0);
    end
    step();
    chk1("b2b_done", a_done, 1'b1);
    chk1("b2b_rdy_in_done", a_rdy, 1'b1);
    step();
    a_vld = 1'b0;
    chk1("b2b_second_busy", a_busy, 1'b1);
    chk1("b2b_done_clear", a_done, 1'b0);
    a_col = 3'b011;
    #1;
    chk4("b2b_k9_row", a_row, 4'b1011);
    step();
    chk4("b2b_k9_row_hold2", a_row, 4'b1011);

    // Reset mid-HOLD releases the contact without a clock edge
    reset = 1'b0;
    #1;
    chk4("rst_mid_row", a_row, 4'b1111);
    chk1("rst_mid_busy", a_busy, 1'b0);
    #1;
    reset = 1'b1;
    step();
    chk1("rst_rel_rdy", a_rdy, 1'b1);
    chk1("rst_rel_busy", a_busy, 1'b0);
    chk4("rst_rel_row", a_row, 4'b1111);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
